// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program-counter fetch sequencer with single outstanding imem request
// Owns the fetch PC, issues one request at a time and hands instructions to decode.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fetch_pc;
  logic        kill;
  logic [31:0] target;

  assign target      = {branch_target[31:2], 2'b00};
  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == OUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      fetch_pc     <= RESET_PC;
      kill         <= 1'b0;
      instr        <= 32'h0;
      instr_pc     <= 32'h0;
      misalign_err <= 1'b0;
      fetch_cnt    <= 32'h0;
    end else begin
      misalign_err <= branch_taken && (branch_target[1:0] != 2'b00);
      case (state)
        IDLE: begin
          if (branch_taken) pc <= target;
          state <= REQ;
        end
        REQ: begin
          if (branch_taken) begin
            pc <= target;
            // A grant racing the redirect is a wrong-path fetch; drain it killed.
            if (imem_gnt) begin
              fetch_pc <= pc;
              kill     <= 1'b1;
              state    <= WAIT;
            end
          end else if (imem_gnt) begin
            fetch_pc <= pc;
            pc       <= pc + PC_STEP;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (branch_taken) begin
            pc <= target;
            if (imem_rvalid) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else begin
              instr    <= imem_rdata;
              instr_pc <= fetch_pc;
              state    <= OUT;
            end
          end
        end
        OUT: begin
          if (branch_taken) begin
            pc    <= target;
            state <= REQ;
          end else if (instr_ready) begin
            fetch_cnt <= fetch_cnt + 32'h1;
            state     <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
